// File: rtl/alu_operand_store.sv
// Operand/result store between the input latch and the ALU core: loads an operand
// pair, writes ALU results back for accumulator chaining, and keeps a result history FIFO.
module alu_operand_store #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     active,
    input  logic [2*WIDTH-1:0]       data_AB,
    input  logic                     pos_save,
    input  logic                     done,
    input  logic [WIDTH-1:0]         data_result,
    input  logic                     acc_mode,
    input  logic                     hist_pop,
    output logic [WIDTH-1:0]         data_outA,
    output logic [WIDTH-1:0]         data_outB,
    output logic                     operands_valid,
    output logic [WIDTH-1:0]         hist_data,
    output logic [$clog2(DEPTH):0]   hist_count,
    output logic                     hist_empty,
    output logic                     hist_full,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, READY} state_t;

    state_t             state;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;

    logic               push_req;
    logic               push_ok;
    logic               pop_ok;
    logic [CW-1:0]      count_nxt;
    logic [PW-1:0]      rd_nxt;
    logic [WIDTH-1:0]   head_nxt;

    assign operands_valid = (state == READY);

    always_comb begin
        push_req  = done && (state == READY);
        pop_ok    = hist_pop && (hist_count != '0);
        // A pop in the same cycle frees the slot a full history needs for the push.
        push_ok   = push_req && ((hist_count != CW'(DEPTH)) || pop_ok);
        count_nxt = hist_count + CW'(push_ok) - CW'(pop_ok);
        rd_nxt    = rd_ptr + PW'(pop_ok);
        head_nxt  = '0;
        if (count_nxt != '0) begin
            // The new head is the incoming result only when it lands in the head slot.
            if (push_ok && (wr_ptr == rd_nxt))
                head_nxt = data_result;
            else
                head_nxt = mem[rd_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            data_outA  <= '0;
            data_outB  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            hist_count <= '0;
            hist_data  <= '0;
            hist_empty <= 1'b1;
            hist_full  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (active) begin
                state <= READY;
                if (pos_save) begin
                    data_outA <= data_AB[2*WIDTH-1:WIDTH];
                    data_outB <= data_AB[WIDTH-1:0];
                end else begin
                    data_outB <= data_AB[2*WIDTH-1:WIDTH];
                    data_outA <= data_AB[WIDTH-1:0];
                end
            end else if (push_req && acc_mode) begin
                if (pos_save)
                    data_outA <= data_result;
                else
                    data_outB <= data_result;
            end
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (push_req && !push_ok)
                overflow <= 1'b1;
            rd_ptr     <= rd_nxt;
            hist_count <= count_nxt;
            hist_data  <= head_nxt;
            hist_empty <= (count_nxt == '0);
            hist_full  <= (count_nxt == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok)
            mem[wr_ptr] <= data_result;
    end

endmodule

// File: tb/tb_alu_operand_store.sv
// Bench for alu_operand_store: directed vector table followed by randomized
// stimulus compared against a queue-based reference model.
module tb_alu_operand_store;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst, active, pos_save, done, acc_mode, hist_pop;
    logic [7:0]       data_AB;
    logic [3:0]       data_result;
    logic [3:0]       data_outA, data_outB, hist_data;
    logic [2:0]       hist_count;
    logic             operands_valid, hist_empty, hist_full, overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_operand_store #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .active(active), .data_AB(data_AB),
        .pos_save(pos_save), .done(done), .data_result(data_result),
        .acc_mode(acc_mode), .hist_pop(hist_pop),
        .data_outA(data_outA), .data_outB(data_outB),
        .operands_valid(operands_valid), .hist_data(hist_data),
        .hist_count(hist_count), .hist_empty(hist_empty),
        .hist_full(hist_full), .overflow(overflow)
    );

    typedef struct {
        logic       rst, active, pos_save;
        logic [7:0] ab;
        logic       done;
        logic [3:0] res;
        logic       acc, pop;
        logic [3:0] ea, eb;
        logic       ev;
        logic [2:0] ec;
        logic [3:0] ehd;
        logic       eo;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic a, input logic ps, input logic [7:0] ab,
                       input logic d, input logic [3:0] res, input logic acc, input logic pop,
                       input logic [3:0] ea, input logic [3:0] eb, input logic ev,
                       input logic [2:0] ec, input logic [3:0] ehd, input logic eo);
        vec_t v;
        v.rst = r; v.active = a; v.pos_save = ps; v.ab = ab; v.done = d; v.res = res;
        v.acc = acc; v.pop = pop; v.ea = ea; v.eb = eb; v.ev = ev; v.ec = ec;
        v.ehd = ehd; v.eo = eo;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic a, input logic ps, input logic [7:0] ab,
                         input logic d, input logic [3:0] res, input logic acc, input logic pop);
        rst = r; active = a; pos_save = ps; data_AB = ab; done = d;
        data_result = res; acc_mode = acc; hist_pop = pop;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int ea, input int eb, input int ev,
                             input int ec, input int ehd, input int eo);
        chk({tag, " data_outA"}, data_outA, ea);
        chk({tag, " data_outB"}, data_outB, eb);
        chk({tag, " operands_valid"}, operands_valid, ev);
        chk({tag, " hist_count"}, hist_count, ec);
        chk({tag, " hist_data"}, hist_data, ehd);
        chk({tag, " overflow"}, overflow, eo);
        chk({tag, " hist_empty"}, hist_empty, int'(ec == 0));
        chk({tag, " hist_full"}, hist_full, int'(ec == DEPTH));
    endtask

    // reference model state
    int  mq[$];
    int  ma, mb;
    bit  mready, movf;

    initial begin
        rst = 1; active = 0; pos_save = 0; data_AB = 0; done = 0;
        data_result = 0; acc_mode = 0; hist_pop = 0;

        //  rst act ps ab     done res  acc pop  A     B     v  cnt hd    ovf
        add(1, 0, 0, 8'h00, 0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0);
        add(0, 0, 0, 8'h00, 1, 4'h9, 1, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0); // done in IDLE
        add(0, 1, 1, 8'hA5, 0, 4'h0, 0, 0, 4'hA, 4'h5, 1, 0, 4'h0, 0);
        add(0, 1, 0, 8'hA5, 0, 4'h0, 0, 0, 4'h5, 4'hA, 1, 0, 4'h0, 0);
        add(0, 1, 1, 8'h37, 0, 4'h0, 0, 0, 4'h3, 4'h7, 1, 0, 4'h0, 0);
        add(0, 0, 0, 8'h00, 1, 4'hC, 1, 0, 4'h3, 4'hC, 1, 1, 4'hC, 0); // writeback to B
        add(0, 0, 1, 8'h00, 1, 4'h5, 0, 0, 4'h3, 4'hC, 1, 2, 4'hC, 0); // acc_mode=0
        add(0, 0, 0, 8'h00, 0, 4'h0, 0, 1, 4'h3, 4'hC, 1, 1, 4'h5, 0);
        add(0, 0, 0, 8'h00, 0, 4'h0, 0, 1, 4'h3, 4'hC, 1, 0, 4'h0, 0);
        add(0, 0, 0, 8'h00, 0, 4'h0, 0, 1, 4'h3, 4'hC, 1, 0, 4'h0, 0); // pop when empty
        add(0, 0, 0, 8'h00, 1, 4'h1, 0, 0, 4'h3, 4'hC, 1, 1, 4'h1, 0);
        add(0, 0, 0, 8'h00, 1, 4'h2, 0, 0, 4'h3, 4'hC, 1, 2, 4'h1, 0);
        add(0, 0, 0, 8'h00, 1, 4'h3, 0, 0, 4'h3, 4'hC, 1, 3, 4'h1, 0);
        add(0, 0, 0, 8'h00, 1, 4'h4, 0, 0, 4'h3, 4'hC, 1, 4, 4'h1, 0);
        add(0, 0, 0, 8'h00, 1, 4'h5, 0, 0, 4'h3, 4'hC, 1, 4, 4'h1, 1); // dropped
        add(0, 0, 0, 8'h00, 0, 4'h0, 0, 1, 4'h3, 4'hC, 1, 3, 4'h2, 1);
        add(0, 0, 0, 8'h00, 0, 4'h0, 0, 1, 4'h3, 4'hC, 1, 2, 4'h3, 1);
        add(0, 0, 0, 8'h00, 1, 4'h6, 0, 0, 4'h3, 4'hC, 1, 3, 4'h3, 1);
        add(0, 0, 0, 8'h00, 1, 4'h7, 0, 0, 4'h3, 4'hC, 1, 4, 4'h3, 1); // wrapped
        add(0, 0, 0, 8'h00, 0, 4'h0, 0, 1, 4'h3, 4'hC, 1, 3, 4'h4, 1);
        add(0, 0, 0, 8'h00, 0, 4'h0, 0, 1, 4'h3, 4'hC, 1, 2, 4'h6, 1);
        add(0, 0, 0, 8'h00, 0, 4'h0, 0, 1, 4'h3, 4'hC, 1, 1, 4'h7, 1);
        add(0, 0, 0, 8'h00, 0, 4'h0, 0, 1, 4'h3, 4'hC, 1, 0, 4'h0, 1);
        add(0, 1, 1, 8'h12, 1, 4'hF, 1, 0, 4'h1, 4'h2, 1, 1, 4'hF, 1); // load wins
        add(1, 0, 0, 8'h00, 0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0);
        add(0, 1, 1, 8'h00, 0, 4'h0, 0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 0);
        add(0, 0, 0, 8'h00, 1, 4'h1, 0, 0, 4'h0, 4'h0, 1, 1, 4'h1, 0);
        add(0, 0, 0, 8'h00, 1, 4'h2, 0, 0, 4'h0, 4'h0, 1, 2, 4'h1, 0);
        add(0, 0, 0, 8'h00, 1, 4'h3, 0, 0, 4'h0, 4'h0, 1, 3, 4'h1, 0);
        add(0, 0, 0, 8'h00, 1, 4'h4, 0, 0, 4'h0, 4'h0, 1, 4, 4'h1, 0);
        add(0, 0, 0, 8'h00, 1, 4'h8, 0, 1, 4'h0, 4'h0, 1, 4, 4'h2, 0); // full push+pop
        add(1, 1, 1, 8'hFF, 1, 4'h9, 1, 1, 4'h0, 4'h0, 0, 0, 4'h0, 0);
        add(0, 1, 0, 8'h34, 0, 4'h0, 0, 0, 4'h4, 4'h3, 1, 0, 4'h0, 0);
        add(0, 0, 0, 8'h00, 1, 4'h1, 0, 0, 4'h4, 4'h3, 1, 1, 4'h1, 0);
        add(0, 0, 0, 8'h00, 1, 4'h2, 0, 0, 4'h4, 4'h3, 1, 2, 4'h1, 0);
        add(0, 0, 0, 8'h00, 1, 4'h3, 0, 0, 4'h4, 4'h3, 1, 3, 4'h1, 0);
        add(0, 0, 0, 8'h00, 1, 4'h4, 0, 0, 4'h4, 4'h3, 1, 4, 4'h1, 0);
        add(0, 0, 0, 8'h00, 1, 4'h5, 0, 0, 4'h4, 4'h3, 1, 4, 4'h1, 1);
        add(0, 0, 0, 8'h00, 0, 4'h0, 0, 1, 4'h4, 4'h3, 1, 3, 4'h2, 1);
        add(1, 1, 1, 8'hAB, 1, 4'hE, 1, 1, 4'h0, 4'h0, 0, 0, 4'h0, 0); // rst mid-op
        add(0, 0, 0, 8'h00, 1, 4'h9, 1, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].active, vecs[i].pos_save, vecs[i].ab,
                  vecs[i].done, vecs[i].res, vecs[i].acc, vecs[i].pop);
            check_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ev,
                      vecs[i].ec, vecs[i].ehd, vecs[i].eo);
        end

        // Randomized phase: directed table ended in IDLE with an empty history.
        mq.delete(); ma = 0; mb = 0; mready = 0; movf = 0;
        for (int n = 0; n < 600; n++) begin
            logic r, a, ps, d, acc, pop;
            logic [7:0] ab;
            logic [3:0] res;
            bit push, pop_ok, can_push;
            r   = ($urandom_range(0, 59) == 0);
            a   = ($urandom_range(0, 5) == 0);
            ps  = $urandom_range(0, 1);
            d   = ($urandom_range(0, 2) != 0);
            acc = $urandom_range(0, 1);
            pop = ($urandom_range(0, 2) == 0);
            ab  = 8'($urandom);
            res = 4'($urandom);
            drive(r, a, ps, ab, d, res, acc, pop);
            if (r) begin
                mq.delete(); ma = 0; mb = 0; mready = 0; movf = 0;
            end else begin
                push     = d && mready;
                pop_ok   = pop && (mq.size() > 0);
                can_push = push && (mq.size() < DEPTH || pop_ok);
                if (pop_ok) void'(mq.pop_front());
                if (can_push) mq.push_back(int'(res));
                if (push && !can_push) movf = 1;
                if (a) begin
                    if (ps) begin ma = ab / 16; mb = ab % 16; end
                    else begin mb = ab / 16; ma = ab % 16; end
                    mready = 1;
                end else if (push && acc) begin
                    if (ps) ma = res; else mb = res;
                end
            end
            check_all($sformatf("rnd%0d", n), ma, mb, mready, mq.size(),
                      (mq.size() > 0) ? mq[0] : 0, movf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
